// File: rtl/ldm_stm_sequencer.sv
// Expands one LDM/STM into one micro-op per listed register, then optionally
// strobes the final base value back to Rn. Fetch/decode is frozen while busy.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [3:0]        base_rn,
  input  logic [ADDR_W-1:0] base_val,
  input  logic              load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  input  logic              uop_ready,
  output logic              freeze,
  output logic              uop_valid,
  output logic [3:0]        uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_load,
  output logic              uop_last,
  output logic              base_wb_en,
  output logic [3:0]        base_wb_dest,
  output logic [ADDR_W-1:0] base_wb_val
);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, WB} state_t;

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  state_t            state, state_nx;
  logic [15:0]       list_q;
  logic [3:0]        rn_q;
  logic              load_q, up_q, pre_q, wback_q, wb_go_q;
  logic [ADDR_W-1:0] base_q, addr_q, final_q;

  logic [4:0]        count;
  logic [ADDR_W-1:0] span, start_addr;
  logic [15:0]       lowest;
  logic [3:0]        lowest_idx;
  logic              one_left;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) count = count + 5'(list_q[i]);
  end

  assign span = ADDR_W'(count) << 2;

  always_comb begin
    start_addr = base_q;
    case ({pre_q, up_q})
      2'b01:   start_addr = base_q;
      2'b11:   start_addr = base_q + WORD;
      2'b00:   start_addr = base_q - span + WORD;
      default: start_addr = base_q - span;
    endcase
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = 15; i >= 0; i--) if (list_q[i]) lowest_idx = 4'(i);
  end

  assign lowest   = list_q & (~list_q + 16'd1);
  assign one_left = (list_q != 16'd0) && ((list_q & (list_q - 16'd1)) == 16'd0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    state_nx = (count == 5'd0) ? IDLE : ISSUE;
      ISSUE:   if (uop_ready && one_left) state_nx = wb_go_q ? WB : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      list_q  <= '0;
      rn_q    <= '0;
      load_q  <= 1'b0;
      up_q    <= 1'b0;
      pre_q   <= 1'b0;
      wback_q <= 1'b0;
      wb_go_q <= 1'b0;
      base_q  <= '0;
      addr_q  <= '0;
      final_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          list_q  <= reg_list;
          rn_q    <= base_rn;
          load_q  <= load;
          up_q    <= up;
          pre_q   <= pre;
          wback_q <= wback;
          base_q  <= base_val;
        end
        CALC: begin
          addr_q  <= start_addr;
          final_q <= up_q ? base_q + span : base_q - span;
          // A loaded base overrides write-back, so decide it before bits are consumed.
          wb_go_q <= wback_q && !(load_q && list_q[rn_q]);
        end
        ISSUE: if (uop_ready) begin
          list_q <= list_q & ~lowest;
          addr_q <= addr_q + WORD;
        end
        default: ;
      endcase
    end
  end

  assign freeze       = (state != IDLE);
  assign uop_valid    = (state == ISSUE);
  assign uop_reg      = lowest_idx;
  assign uop_addr     = addr_q;
  assign uop_load     = load_q;
  assign uop_last     = (state == ISSUE) && one_left;
  assign base_wb_en   = (state == WB);
  assign base_wb_dest = rn_q;
  assign base_wb_val  = final_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: expected micro-ops and write-backs are
// queued per instruction and compared as the DUT hands them over.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] reg_list = '0;
  logic [3:0]  base_rn = '0;
  logic [31:0] base_val = '0;
  logic        load = 1'b0, up = 1'b0, pre = 1'b0, wback = 1'b0;
  logic        uop_ready = 1'b1;
  logic        freeze, uop_valid, uop_load, uop_last, base_wb_en;
  logic [3:0]  uop_reg, base_wb_dest;
  logic [31:0] uop_addr, base_wb_val;

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_list(reg_list),
    .base_rn(base_rn), .base_val(base_val), .load(load), .up(up),
    .pre(pre), .wback(wback), .uop_ready(uop_ready), .freeze(freeze),
    .uop_valid(uop_valid), .uop_reg(uop_reg), .uop_addr(uop_addr),
    .uop_load(uop_load), .uop_last(uop_last), .base_wb_en(base_wb_en),
    .base_wb_dest(base_wb_dest), .base_wb_val(base_wb_val)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] a;
    logic        ld;
    logic        last;
  } op_t;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] val;
  } wb_t;

  op_t op_q[$];
  wb_t wb_q[$];

  int checks = 0;
  int fails  = 0;
  int freeze_cycles = 0;
  int valid_cycles  = 0;
  int wb_cycles     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: consume expectations as the DUT produces accepted ops and strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (freeze)     freeze_cycles++;
      if (uop_valid)  valid_cycles++;
      if (base_wb_en) wb_cycles++;
      if (uop_valid && uop_ready) begin
        check("uop_expected", 32'(op_q.size() != 0), 32'd1);
        if (op_q.size() != 0) begin
          op_t e;
          e = op_q.pop_front();
          check("uop_reg",  32'(uop_reg),  32'(e.r));
          check("uop_addr", uop_addr,      e.a);
          check("uop_load", 32'(uop_load), 32'(e.ld));
          check("uop_last", 32'(uop_last), 32'(e.last));
        end
      end
      if (base_wb_en) begin
        check("wb_overlaps_uop", 32'(uop_valid), 32'd0);
        check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
        if (wb_q.size() != 0) begin
          wb_t w;
          w = wb_q.pop_front();
          check("wb_dest", 32'(base_wb_dest), 32'(w.dest));
          check("wb_val",  base_wb_val,       w.val);
        end
      end
    end
  end

  task automatic push_op(input logic [3:0] r, input logic [31:0] a, input logic ld, input logic last);
    op_t e;
    e.r = r; e.a = a; e.ld = ld; e.last = last;
    op_q.push_back(e);
  endtask

  task automatic push_wb(input logic [3:0] d, input logic [31:0] v);
    wb_t w;
    w.dest = d; w.val = v;
    wb_q.push_back(w);
  endtask

  // Returns just after the edge that samples start (state is now CALC).
  task automatic drive(input logic [15:0] l, input logic [3:0] rn, input logic [31:0] b,
                       input logic ld, input logic u, input logic p, input logic w);
    @(posedge clk); #1;
    reg_list = l; base_rn = rn; base_val = b;
    load = ld; up = u; pre = p; wback = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (freeze && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(freeze), 32'd0);
  endtask

  task automatic check_done(input string tag, input int f0, input int v0, input int w0,
                            input int f_exp, input int v_exp, input int w_exp);
    check({tag, "_freeze_cycles"}, 32'(freeze_cycles - f0), 32'(f_exp));
    check({tag, "_valid_cycles"},  32'(valid_cycles - v0),  32'(v_exp));
    check({tag, "_wb_cycles"},     32'(wb_cycles - w0),     32'(w_exp));
    check({tag, "_ops_left"},      32'(op_q.size()),        32'd0);
    check({tag, "_wbs_left"},      32'(wb_q.size()),        32'd0);
  endtask

  initial begin
    int f0, v0, w0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_valid",  32'(uop_valid), 32'd0);
    check("rst_wb_en",  32'(base_wb_en), 32'd0);
    check("rst_addr",   uop_addr, 32'd0);
    check("rst_wb_val", base_wb_val, 32'd0);

    // STMIA R13=0x100, {R1-R3}, W=1
    push_op(4'd1, 32'h100, 1'b0, 1'b0);
    push_op(4'd2, 32'h104, 1'b0, 1'b0);
    push_op(4'd3, 32'h108, 1'b0, 1'b1);
    push_wb(4'd13, 32'h10C);
    f0 = freeze_cycles; v0 = valid_cycles; w0 = wb_cycles;
    drive(16'h000E, 4'd13, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("calc_freeze", 32'(freeze), 32'd1);
    check("calc_no_valid", 32'(uop_valid), 32'd0);
    wait_idle();
    check_done("stmia", f0, v0, w0, 5, 3, 1);

    // LDMDB R2=0x200, {R0,R4,R15}, W=1
    push_op(4'd0,  32'h1F4, 1'b1, 1'b0);
    push_op(4'd4,  32'h1F8, 1'b1, 1'b0);
    push_op(4'd15, 32'h1FC, 1'b1, 1'b1);
    push_wb(4'd2, 32'h1F4);
    f0 = freeze_cycles; v0 = valid_cycles; w0 = wb_cycles;
    drive(16'h8011, 4'd2, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle();
    check_done("ldmdb", f0, v0, w0, 5, 3, 0 + 1);

    // LDMIA R1=0x300, {R0,R1}, W=1: loaded base wins; extra start in ISSUE ignored
    push_op(4'd0, 32'h300, 1'b1, 1'b0);
    push_op(4'd1, 32'h304, 1'b1, 1'b1);
    f0 = freeze_cycles; v0 = valid_cycles; w0 = wb_cycles;
    drive(16'h0003, 4'd1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    reg_list = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("ignored_start_freeze", 32'(freeze), 32'd0);
    check_done("ldmia", f0, v0, w0, 3, 2, 0);

    // STMIB R5=0x0, {R0}, W=0, ready low for 3 cycles
    uop_ready = 1'b0;
    push_op(4'd0, 32'h4, 1'b0, 1'b1);
    f0 = freeze_cycles; v0 = valid_cycles; w0 = wb_cycles;
    drive(16'h0001, 4'd5, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(uop_valid), 32'd1);
      check("stall_reg",   32'(uop_reg), 32'd0);
      check("stall_addr",  uop_addr, 32'h4);
      @(posedge clk); #1;
    end
    uop_ready = 1'b1;
    wait_idle();
    check_done("stmib", f0, v0, w0, 5, 4, 0);

    // Empty list, W=1
    f0 = freeze_cycles; v0 = valid_cycles; w0 = wb_cycles;
    drive(16'h0000, 4'd7, 32'h500, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check_done("empty", f0, v0, w0, 1, 0, 0);

    // STMDB R9=0x0, {R0}, W=1: address and base wrap
    push_op(4'd0, 32'hFFFF_FFFC, 1'b0, 1'b1);
    push_wb(4'd9, 32'hFFFF_FFFC);
    f0 = freeze_cycles; v0 = valid_cycles; w0 = wb_cycles;
    drive(16'h0001, 4'd9, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_idle();
    check_done("wrap", f0, v0, w0, 3, 1, 1);

    // STMDA R3=0x400, {R4-R7}, W=1, reset during second op
    push_op(4'd4, 32'h3F4, 1'b0, 1'b0);
    w0 = wb_cycles;
    drive(16'h00F0, 4'd3, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    uop_ready = 1'b0;
    @(negedge clk);
    check("second_op_reg",  32'(uop_reg), 32'd5);
    check("second_op_addr", uop_addr, 32'h3F8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_freeze",  32'(freeze), 32'd0);
    check("abort_valid",   32'(uop_valid), 32'd0);
    check("abort_last",    32'(uop_last), 32'd0);
    check("abort_load",    32'(uop_load), 32'd0);
    check("abort_reg",     32'(uop_reg), 32'd0);
    check("abort_addr",    uop_addr, 32'd0);
    check("abort_wb_en",   32'(base_wb_en), 32'd0);
    check("abort_wb_dest", 32'(base_wb_dest), 32'd0);
    check("abort_wb_val",  base_wb_val, 32'd0);
    uop_ready = 1'b1;
    v0 = valid_cycles;
    repeat (10) @(negedge clk);
    check("abort_no_more_ops", 32'(valid_cycles - v0), 32'd0);
    check("abort_no_wb",       32'(wb_cycles - w0), 32'd0);
    check("abort_ops_left",    32'(op_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-register transfer sequencer for the ARM968E-S pipeline. It sits directly upstream of the register file: it expands one LDM/STM instruction into one micro-op per listed register and drives the register index (read source for stores, write-back destination for loads) and the word address for each. It computes the final base-register update and freezes fetch/decode while a transfer is in progress.

## Interface
Parameters:
- `ADDR_W`, default 32: address and data width.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  decode presents a valid LDM/STM this cycle; sampled only in IDLE.
- `reg_list`  in  16  register list, bit i selects Ri.
- `base_rn`  in  4  base register index.
- `base_val`  in  ADDR_W  current value of Rn from the register file read port.
- `load`  in  1  L bit: 1 = LDM, 0 = STM.
- `up`  in  1  U bit: 1 = increment, 0 = decrement.
- `pre`  in  1  P bit: 1 = before, 0 = after.
- `wback`  in  1  W bit: base write-back requested.
- `uop_ready`  in  1  memory stage accepts the current micro-op.
- `freeze`  out  1  high whenever state is not IDLE; stalls fetch/decode.
- `uop_valid`  out  1  micro-op valid.
- `uop_reg`  out  4  register index for this micro-op.
- `uop_addr`  out  ADDR_W  word address for this micro-op.
- `uop_load`  out  1  copy of latched L bit.
- `uop_last`  out  1  marks the final micro-op.
- `base_wb_en`  out  1  one-cycle base write-back strobe.
- `base_wb_dest`  out  4  latched Rn.
- `base_wb_val`  out  ADDR_W  updated base value.

## Operation
- States: IDLE, CALC, ISSUE, WB.
- IDLE: on `start`=1 latch all instruction inputs and `base_val`; go to CALC. `start` is ignored in all other states.
- CALC (1 cycle): N = popcount(latched list), 0..16. Start address S: IA (P0,U1) = Rn; IB (P1,U1) = Rn+4; DA (P0,U0) = Rn−4N+4; DB (P1,U0) = Rn−4N. Final base F = Rn+4N if U=1, else Rn−4N. All arithmetic modulo 2^ADDR_W. If N=0 go to IDLE (no micro-ops, no write-back); else go to ISSUE.
- ISSUE: `uop_valid`=1; `uop_reg` = lowest-numbered still-pending list bit; `uop_addr` = S + 4·k for the k-th issued op (k from 0), so the lowest register always takes the lowest address for every mode. `uop_last`=1 when exactly one bit remains pending. When `uop_valid` and `uop_ready` are both 1, clear that bit and advance the address. Outputs hold stable while `uop_ready`=0.
- After the last op is accepted: go to WB if `wback`=1 and not (load=1 and Rn in list); otherwise go to IDLE. On LDM with Rn listed, the loaded value wins; no base write-back occurs.
- WB (1 cycle): `base_wb_en`=1, `base_wb_val`=F, `base_wb_dest`=Rn; then go to IDLE.
- R15 in the list is transferred like any other register; PC semantics are handled downstream.

## Timing
- Reset: state IDLE, pending list 0; `freeze`, `uop_valid`, `uop_last`, `base_wb_en`, `uop_load` = 0; `uop_reg`, `base_wb_dest` = 0; `uop_addr`, `base_wb_val` = 0.
- Reset mid-operation aborts immediately: no further micro-ops and no write-back.
- `freeze` rises in the cycle after `start` is sampled and falls in the cycle after the final state (ISSUE or WB) exits.
- First `uop_valid` appears 2 cycles after `start` is sampled (IDLE→CALC→ISSUE).
- With `uop_ready` held high: one micro-op per cycle, so N ops take N cycles. Total busy time is 1+N+(1 if WB) cycles.
- The write-back strobe fires when the register file next commits it (negedge write); it never overlaps `uop_valid`.

## Test plan
- STMIA, Rn=R13=0x100, list=0x000E, W=1, ready=1: ops R1@0x100, R2@0x104, R3@0x108 (last on R3), then WB R13=0x10C. `freeze` high for 5 cycles.
- LDMDB, Rn=R2=0x200, list=0x8011, W=1: ops R0@0x1F4, R4@0x1F8, R15@0x1FC, then WB R2=0x1F4.
- LDMIA, Rn=R1, list=0x0003, W=1: ops R0, R1; no `base_wb_en`; return to IDLE.
- STMIB, Rn=0x0, list=0x0001, with `uop_ready` low for 3 cycles: R0@0x4 held stable for 4 cycles, then accepted; no WB since W=0.
- Empty list with `start`=1: `freeze` high for exactly 1 cycle; no `uop_valid`, no `base_wb_en`. A second `start` pulse during ISSUE is ignored.
- `rst`=1 during the second op of a 4-register STMDA: next cycle all outputs are 0 and state is IDLE; no write-back ever fires.
